// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: register-mapped GPIO port with pad synchronizers, per-line debounce and edge interrupts
//   clk    : single clock, all state on rising edge
//   rst    : asynchronous active-high reset
//   wr_en  : register write strobe
//   rd_en  : register read strobe
//   addr   : register address (0 DATA_OUT, 1 DIR, 2 DATA_IN, 3 IRQ_EN, 4 IRQ_EDGE, 5 IRQ_STAT)
//   wdata  : write data
//   rdata  : registered read data, held between reads
//   gpio_t : pad tristate enable, 1 = hi-Z
//   gpio_o : pad drive value
//   gpio_i : asynchronous pad readback
//   irq    : level interrupt, OR of enabled status bits
module gpio_port_ctrl #(
    parameter int NUM_IO    = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [2:0]        addr,
    input  logic [NUM_IO-1:0] wdata,
    output logic [NUM_IO-1:0] rdata,
    output logic [NUM_IO-1:0] gpio_t,
    output logic [NUM_IO-1:0] gpio_o,
    input  logic [NUM_IO-1:0] gpio_i,
    output logic              irq
);
    localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

    logic [NUM_IO-1:0]      data_out_q, data_out_d;
    logic [NUM_IO-1:0]      dir_q, dir_d;
    logic [NUM_IO-1:0]      irq_en_q, irq_en_d;
    logic [NUM_IO-1:0]      irq_edge_q, irq_edge_d;
    logic [NUM_IO-1:0]      irq_stat_q, irq_stat_d;
    logic [NUM_IO-1:0]      rdata_q, rdata_d;
    logic [NUM_IO-1:0]      sync1_q, sync1_d;
    logic [NUM_IO-1:0]      sync2_q, sync2_d;
    logic [NUM_IO-1:0]      stb_q, stb_d;
    logic [NUM_IO-1:0]      stb_hist_q, stb_hist_d;
    logic [NUM_IO-1:0][7:0] cnt_q, cnt_d;
    logic [NUM_IO-1:0]      rd_val, hw_set, sw_clr;

    always_comb begin
        data_out_d = (wr_en && addr == 3'd0) ? wdata : data_out_q;
        dir_d      = (wr_en && addr == 3'd1) ? wdata : dir_q;
        irq_en_d   = (wr_en && addr == 3'd3) ? wdata : irq_en_q;
        irq_edge_d = (wr_en && addr == 3'd4) ? wdata : irq_edge_q;
        // read mux uses pre-write register values, so a same-cycle read sees the old contents
        rd_val = (addr == 3'd0) ? data_out_q :
                 (addr == 3'd1) ? dir_q :
                 (addr == 3'd2) ? stb_q :
                 (addr == 3'd3) ? irq_en_q :
                 (addr == 3'd4) ? irq_edge_q :
                 (addr == 3'd5) ? irq_stat_q : '0;
        rdata_d = rd_en ? rd_val : rdata_q;
        sync1_d = gpio_i;
        sync2_d = sync1_q;
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        // counter tracks consecutive cycles where the synchronized pin disagrees with stb
        for (int i = 0; i < NUM_IO; i++) begin
            stb_d[i] = (sync2_q[i] != stb_q[i] && cnt_q[i] == CNT_MAX) ? sync2_q[i] : stb_q[i];
            cnt_d[i] = (sync2_q[i] == stb_q[i] || cnt_q[i] == CNT_MAX) ? 8'd0 : cnt_q[i] + 8'd1;
        end
        stb_hist_d = stb_q;
        hw_set = (stb_q & ~stb_hist_q & irq_edge_q) | (~stb_q & stb_hist_q & ~irq_edge_q);
        sw_clr = (wr_en && addr == 3'd5) ? wdata : '0;
        // set applied after clear so a simultaneous event is never lost
        irq_stat_d = (irq_stat_q & ~sw_clr) | hw_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
            irq_stat_q <= '0;
            rdata_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            stb_q      <= '0;
            stb_hist_q <= '0;
            cnt_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_edge_q <= irq_edge_d;
            irq_stat_q <= irq_stat_d;
            rdata_q    <= rdata_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stb_q      <= stb_d;
            stb_hist_q <= stb_hist_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rdata  = rdata_q;
    assign gpio_o = data_out_q;
    assign gpio_t = ~dir_q;
    assign irq    = |(irq_stat_q & irq_en_q);
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: vector table, directed corner sequences and randomized model comparison for gpio_port_ctrl
module tb_gpio_port_ctrl;
    localparam int NW = 2;
    localparam int DB = 4;
    localparam int RN = 2000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [2:0]    addr = 3'd0;
    logic [NW-1:0] wdata = '0;
    logic [NW-1:0] gpio_i = '0;
    logic [NW-1:0] rdata, gpio_t, gpio_o;
    logic          irq;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    gpio_port_ctrl #(.NUM_IO(NW), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .gpio_t(gpio_t), .gpio_o(gpio_o), .gpio_i(gpio_i), .irq(irq)
    );

    typedef struct {
        logic       w;
        logic       r;
        logic [2:0] a;
        logic [1:0] d;
        logic [1:0] e_rd;
        logic [1:0] e_t;
        logic [1:0] e_o;
        logic       e_irq;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic w, r, input logic [2:0] a, input logic [1:0] d, e_rd, e_t, e_o, input logic e_irq);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d; v.e_rd = e_rd; v.e_t = e_t; v.e_o = e_o; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [2:0] a, input logic [NW-1:0] d);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    // reference model: debounce expressed as "last DB synchronized samples since the previous change all disagree"
    logic [NW-1:0] hist [RN+8];
    logic [NW-1:0] m_do, m_dir, m_en, m_edge, m_stat, m_rd, m_stb, m_ev;
    int            lastc [NW];
    int            n;

    function automatic logic s2(input int b, input int k);
        return (k >= 2) ? hist[k-2][b] : 1'b0;
    endfunction

    task automatic model_reset;
        m_do = '0; m_dir = '0; m_en = '0; m_edge = '0; m_stat = '0; m_rd = '0; m_stb = '0; m_ev = '0;
        for (int b = 0; b < NW; b++) lastc[b] = -1;
        n = 0;
    endtask

    task automatic model_step;
        logic [NW-1:0] rv, setv, nstb, clr;
        logic ok;
        hist[n] = gpio_i;
        case (addr)
            3'd0: rv = m_do;
            3'd1: rv = m_dir;
            3'd2: rv = m_stb;
            3'd3: rv = m_en;
            3'd4: rv = m_edge;
            3'd5: rv = m_stat;
            default: rv = '0;
        endcase
        if (rd_en) m_rd = rv;
        for (int b = 0; b < NW; b++) setv[b] = m_ev[b] && (m_stb[b] == m_edge[b]);
        for (int b = 0; b < NW; b++) begin
            ok = 1'b1;
            for (int j = 0; j < DB; j++)
                if (n - j <= lastc[b] || s2(b, n - j) == m_stb[b]) ok = 1'b0;
            nstb[b] = ok ? ~m_stb[b] : m_stb[b];
            if (ok) lastc[b] = n;
        end
        m_ev = nstb ^ m_stb;
        m_stb = nstb;
        clr = '0;
        if (wr_en) begin
            case (addr)
                3'd0: m_do = wdata;
                3'd1: m_dir = wdata;
                3'd3: m_en = wdata;
                3'd4: m_edge = wdata;
                3'd5: clr = wdata;
                default: ;
            endcase
        end
        m_stat = (m_stat & ~clr) | setv;
        n++;
    endtask

    initial begin
        #2;
        chk("rst_hold gpio_t", gpio_t, 2'b11);
        chk("rst_hold gpio_o", gpio_o, 2'b00);
        chk("rst_hold irq", {1'b0, irq}, 2'b00);
        idle(2);
        @(negedge clk) rst = 1'b0;

        tv.push_back(mk(0, 1, 3'd0, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        tv.push_back(mk(0, 1, 3'd1, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        tv.push_back(mk(0, 1, 3'd3, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        tv.push_back(mk(0, 1, 3'd4, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        tv.push_back(mk(0, 1, 3'd5, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        tv.push_back(mk(1, 0, 3'd1, 2'b01, 2'b00, 2'b10, 2'b00, 0));
        tv.push_back(mk(1, 0, 3'd0, 2'b11, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd1, 2'b00, 2'b01, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd0, 2'b00, 2'b11, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd2, 2'b11, 2'b11, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd2, 2'b00, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd6, 2'b11, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd6, 2'b00, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd7, 2'b11, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd7, 2'b00, 2'b00, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd0, 2'b00, 2'b11, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd1, 2'b00, 2'b01, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd3, 2'b10, 2'b01, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd3, 2'b00, 2'b10, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd4, 2'b11, 2'b10, 2'b10, 2'b11, 0));
        tv.push_back(mk(0, 1, 3'd4, 2'b00, 2'b11, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd0, 2'b01, 2'b11, 2'b10, 2'b01, 0));
        tv.push_back(mk(1, 1, 3'd0, 2'b10, 2'b01, 2'b10, 2'b10, 0));
        tv.push_back(mk(0, 1, 3'd0, 2'b00, 2'b10, 2'b10, 2'b10, 0));
        tv.push_back(mk(1, 0, 3'd0, 2'b11, 2'b10, 2'b10, 2'b11, 0));
        tv.push_back(mk(1, 0, 3'd5, 2'b11, 2'b10, 2'b10, 2'b11, 0));
        foreach (tv[i]) begin
            cyc(tv[i].w, tv[i].r, tv[i].a, tv[i].d);
            chk($sformatf("vec%0d rdata", i), rdata, tv[i].e_rd);
            chk($sformatf("vec%0d gpio_t", i), gpio_t, tv[i].e_t);
            chk($sformatf("vec%0d gpio_o", i), gpio_o, tv[i].e_o);
            chk($sformatf("vec%0d irq", i), {1'b0, irq}, {1'b0, tv[i].e_irq});
        end

        // glitch of DB-1 clocks on line 0 is rejected
        gpio_i = 2'b01;
        idle(DB - 1);
        gpio_i = 2'b00;
        idle(10);
        cyc(0, 1, 3'd2, 2'b00);
        chk("glitch data_in", rdata, 2'b00);
        cyc(0, 1, 3'd5, 2'b00);
        chk("glitch irq_stat", rdata, 2'b00);

        // line 0 driven high reaches DATA_IN after sync + debounce
        gpio_i = 2'b01;
        idle(DB + 2);
        cyc(0, 1, 3'd2, 2'b00);
        chk("drive data_in", rdata, 2'b01);
        cyc(0, 1, 3'd5, 2'b00);
        chk("drive rise stat0", rdata, 2'b01);
        chk("drive irq masked", {1'b0, irq}, 2'b00);

        // rising edge on line 1 raises irq on the DB+3rd edge
        gpio_i = 2'b11;
        idle(DB + 2);
        chk("rise irq early", {1'b0, irq}, 2'b00);
        idle(1);
        chk("rise irq on time", {1'b0, irq}, 2'b01);
        cyc(1, 0, 3'd5, 2'b10);
        chk("w1c irq low", {1'b0, irq}, 2'b00);
        cyc(0, 1, 3'd5, 2'b00);
        chk("w1c stat", rdata, 2'b01);

        // edge polarity change alone sets nothing; set beats same-cycle clear
        cyc(1, 0, 3'd5, 2'b11);
        cyc(1, 0, 3'd4, 2'b00);
        cyc(0, 1, 3'd5, 2'b00);
        chk("edge change stat", rdata, 2'b00);
        gpio_i = 2'b01;
        idle(DB + 2);
        cyc(1, 0, 3'd5, 2'b10);
        chk("collide irq", {1'b0, irq}, 2'b01);
        cyc(0, 1, 3'd5, 2'b00);
        chk("collide stat", rdata, 2'b10);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("async rst gpio_t", gpio_t, 2'b11);
        chk("async rst gpio_o", gpio_o, 2'b00);
        chk("async rst irq", {1'b0, irq}, 2'b00);
        @(negedge clk) rst = 1'b0;
        cyc(0, 1, 3'd0, 2'b00); chk("rst rd0", rdata, 2'b00);
        cyc(0, 1, 3'd1, 2'b00); chk("rst rd1", rdata, 2'b00);
        cyc(0, 1, 3'd3, 2'b00); chk("rst rd3", rdata, 2'b00);
        cyc(0, 1, 3'd4, 2'b00); chk("rst rd4", rdata, 2'b00);
        cyc(0, 1, 3'd5, 2'b00); chk("rst rd5", rdata, 2'b00);
        // line 0 held high through reset yields one rising event
        cyc(1, 0, 3'd4, 2'b11);
        idle(2);
        cyc(0, 1, 3'd5, 2'b00);
        chk("held-high stat", rdata, 2'b01);
        chk("held-high irq", {1'b0, irq}, 2'b00);
        cyc(0, 1, 3'd2, 2'b00);
        chk("held-high data_in", rdata, 2'b01);

        // reset mid-debounce restarts the full latency
        gpio_i = 2'b11;
        idle(4);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        idle(DB + 1);
        cyc(0, 1, 3'd2, 2'b00);
        chk("post-rst data_in early", rdata, 2'b00);
        cyc(0, 1, 3'd2, 2'b00);
        chk("post-rst data_in on time", rdata, 2'b11);
        chk("post-rst irq", {1'b0, irq}, 2'b00);

        // randomized run against the reference model
        rst = 1'b1;
        gpio_i = '0;
        idle(2);
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < RN; c++) begin
            wr_en = ($urandom_range(0, 9) < 3);
            rd_en = ($urandom_range(0, 9) < 4);
            addr = 3'($urandom_range(0, 7));
            wdata = NW'($urandom_range(0, 3));
            for (int b = 0; b < NW; b++)
                if ($urandom_range(0, 7) == 0) gpio_i[b] = ~gpio_i[b];
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rand%0d rdata", c), rdata, m_rd);
            chk($sformatf("rand%0d gpio_t", c), gpio_t, ~m_dir);
            chk($sformatf("rand%0d gpio_o", c), gpio_o, m_do);
            chk($sformatf("rand%0d irq", c), {1'b0, irq}, {1'b0, |(m_stat & m_en)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpio_port_ctrl.md
GPIO_PORT_CTRL -- requirements
Module: gpio_port_ctrl

Interface
REQ-001 SHALL provide parameter NUM_IO, default 2, number of GPIO lines (1..32).
REQ-002 SHALL provide parameter DB_CYCLES, default 4, debounce stability length in clocks (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  register write strobe, one cycle per write.
REQ-006 SHALL have port rd_en  input  1  register read strobe.
REQ-007 SHALL have port addr  input  3  register address.
REQ-008 SHALL have port wdata  input  NUM_IO  write data.
REQ-009 SHALL have port rdata  output  NUM_IO  registered read data.
REQ-010 SHALL have port gpio_t  output  NUM_IO  per-line tristate enable to the pad buffers; 1 = hi-Z.
REQ-011 SHALL have port gpio_o  output  NUM_IO  per-line drive value to the pad buffers.
REQ-012 SHALL have port gpio_i  input  NUM_IO  per-line pad readback from the pad buffers; asynchronous.
REQ-013 SHALL have port irq  output  1  level interrupt.

Function
REQ-014 The register map SHALL be: 0 DATA_OUT rw; 1 DIR rw (1 = output); 2 DATA_IN ro; 3 IRQ_EN rw; 4 IRQ_EDGE rw (1 = rising, 0 = falling); 5 IRQ_STAT rw1c; 6-7 unmapped.
REQ-015 gpio_o SHALL equal DATA_OUT, and gpio_t SHALL equal bitwise NOT DIR, both directly from registers.
REQ-016 Writes SHALL take effect at the clock edge on which wr_en is sampled high.
REQ-017 Writes to addr 2, 6 and 7 SHALL be ignored.
REQ-018 rdata SHALL update on the edge after rd_en is sampled high and hold its value until the next read.
REQ-019 Reads of addr 6 and 7 SHALL return 0.
REQ-020 When rd_en and wr_en are high in the same cycle, the read SHALL return the pre-write value.
REQ-021 Each gpio_i bit SHALL pass through a two-flop synchronizer; sync2 is the second-stage output.
REQ-022 Debounce, per bit, with registered stable value stb and counter cnt:
- if sync2 equals stb, cnt SHALL clear to 0;
- else if cnt equals DB_CYCLES-1, stb SHALL load sync2 and cnt SHALL clear;
- else cnt SHALL increment.
REQ-023 A glitch shorter than DB_CYCLES cycles at sync2 SHALL never change stb.
REQ-024 DATA_IN SHALL read stb for all lines regardless of DIR; output lines therefore read back their driven pad level.
REQ-025 A rising edge on stb (0 to 1) with IRQ_EDGE bit 1, or a falling edge with IRQ_EDGE bit 0, SHALL set the IRQ_STAT bit on the following edge.
REQ-026 Edge detection SHALL operate regardless of IRQ_EN.
REQ-027 A write to IRQ_STAT SHALL clear each bit where wdata is 1.
REQ-028 A hardware set SHALL win over a simultaneous write-1-to-clear on the same bit.
REQ-029 irq SHALL be combinational: OR-reduce of (IRQ_STAT AND IRQ_EN).
REQ-030 Pin-to-IRQ_STAT latency SHALL be exactly DB_CYCLES+3 clocks from the first edge that samples the new pin level (2 sync, DB_CYCLES debounce, 1 edge detect).
REQ-031 Changing IRQ_EDGE SHALL NOT set IRQ_STAT by itself; only stb transitions set it.

Reset
REQ-032 On rst high, SHALL asynchronously clear DATA_OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STAT, rdata, cnt and the synchronizer flops.
REQ-033 During reset, gpio_t SHALL be all 1 (all lines hi-Z), gpio_o 0, and irq 0.
REQ-034 stb SHALL reset to 0, and the edge-detect history register SHALL reset to 0.
REQ-035 A line held high through reset SHALL therefore produce one rising event after release; that event sets IRQ_STAT but does not raise irq while IRQ_EN is 0.
REQ-036 Reset asserted mid-debounce SHALL discard the partial count, with no event generated.

Verification (NUM_IO=2, DB_CYCLES=4)
REQ-037 Reset check: assert rst mid-cycle -> gpio_t=2'b11, gpio_o=0, irq=0 immediately; then read addr 0,1,3,4,5 -> all 0.
REQ-038 Output drive: write DIR=2'b01, then DATA_OUT=2'b11 -> gpio_t=2'b10, gpio_o=2'b11 on the write edge; after the debounce latency, read DATA_IN -> bit0=1.
REQ-039 Rising IRQ: IRQ_EN=2'b10, IRQ_EDGE=2'b10, drive gpio_i[1] 0->1 and hold -> IRQ_STAT[1] and irq high exactly 7 clocks after the first sampling edge; write IRQ_STAT=2'b10 -> irq low next cycle.
REQ-040 Glitch reject: gpio_i[0] high for 3 clocks then low -> DATA_IN[0] stays 0 and IRQ_STAT stays 0.
REQ-041 Set/clear collision: arrange an edge event on the same cycle as a write-1-to-clear of that bit -> the bit remains 1.
REQ-042 Read/write same cycle: DATA_OUT=1, then rd_en+wr_en at addr 0 with wdata=2 -> rdata=1, and a subsequent read returns 2.
